regfile_wb_read: RTL and testbench
==================================

Name: regfile_wb_read

Overview:
- Integer register file for the 64-bit ARM pipeline, on the receiving end of the writeback data path.
- Accepts the writeback port (enable, destination, data) from the WB stage.
- Serves two operand reads for the decode stage and latches the read values into the ID/EX boundary.
- Provides same-cycle write-to-read bypass, so a value written back is visible to the instruction being decoded that cycle.

Parameters:
- NREGS, 32, number of architectural registers (index NREGS-1 is XZR).
- DW, 64, register data width.
- AW, 5, register index width; AW must satisfy 2**AW == NREGS.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- RegWrite_reg_wb  input  1  writeback enable from WB stage.
- write_reg  input  AW  writeback destination index.
- data_to_reg  input  DW  writeback data from WB stage.
- read_reg1  input  AW  source index, operand 1.
- read_reg2  input  AW  source index, operand 2.
- stall  input  1  hold read outputs (decode stalled).
- flush  input  1  zero read outputs (bubble into EX).
- read_data1  output  DW  registered operand 1.
- read_data2  output  DW  registered operand 2.

Behaviour:
- Clocking and reset:
  - Single clock domain clk.
  - Reset is asynchronous and active-high on reset.
  - While reset is high, all NREGS entries clear to 0, and read_data1 and read_data2 clear to 0.
  - Reset asserted mid-operation discards any in-flight write that cycle.
- Storage:
  - NREGS x DW array.
  - Index NREGS-1 (X31/XZR) always reads 0.
  - Writes to NREGS-1 are dropped; the array entry is never updated.
- Write:
  - On rising clk, if RegWrite_reg_wb=1 and write_reg != NREGS-1, the entry write_reg takes data_to_reg.
  - Exactly one write port; no write ordering issues.
- Read path: 1-cycle latency, registered outputs. For each port N at rising clk:
  - If flush=1: read_dataN <= 0. flush has priority over stall.
  - Else if stall=1: read_dataN holds its value.
  - Else, if read_regN == NREGS-1: read_dataN <= 0.
  - Else, if RegWrite_reg_wb=1 and write_reg == read_regN: read_dataN <= data_to_reg (bypass).
  - Else: read_dataN <= array[read_regN] (pre-edge contents).
- Simultaneous events:
  - Write, and a stalled read of the same index: the array updates, the output holds the old value, and the new value appears on the first non-stalled edge.
  - Both ports reading the same index: both get identical data, including the bypass case.
  - Write to XZR while reading XZR: output is 0, with no bypass.
- Arithmetic: none. Indices compare as unsigned AW-bit values, and every index value is legal.
- No handshake beyond stall/flush; the block never back-pressures WB.

Optional Feature:
- Macro: REGFILE_DBG_EN.
- When defined, the block adds:
  - Input dbg_reg (AW): debug read index.
  - Output dbg_data (DW): combinational array[dbg_reg], with no bypass and 0 for XZR.
  - Output wr_count (32): count of accepted writes. It increments on each rising clk where a write commits (non-XZR), wraps from 0xFFFFFFFF to 0, and resets to 0.
- When not defined, these ports and the counter do not exist, and the core behaviour is identical.

Test Plan:
- Reset test: assert reset asynchronously mid-cycle with read_reg1=3 -> read_data1=0 immediately; after release, all 31 registers read 0 one cycle after being addressed.
- Write then read: write X5=0x0123_4567_89AB_CDEF, then next cycle read_reg1=5 -> read_data1=0x0123_4567_89AB_CDEF one edge later.
- Bypass: same edge RegWrite_reg_wb=1, write_reg=7, data_to_reg=0xDEAD_BEEF, read_reg2=7 with X7 previously 0x11 -> read_data2=0xDEAD_BEEF, not 0x11.
- XZR: write X31=0xFFFF_FFFF_FFFF_FFFF with read_reg1=31 on the same edge and on the next edge -> read_data1=0 both cycles.
- Stall/flush: read_data1=0xAA held under stall=1 while X1 is rewritten to 0xBB -> stays 0xAA, becomes 0xBB after stall drops; stall=1 and flush=1 together -> 0.
- With REGFILE_DBG_EN defined: 3 writes (one to X31) -> wr_count=2; dbg_reg=2 after writing X2=0x42 -> dbg_data=0x42 the same cycle the write commits.

Source files
------------

// File: rtl/regfile_wb_read_if.sv
// Writeback/operand-read bundle for regfile_wb_read.
// REGFILE_DBG_EN adds the debug read port and the write counter.
interface regfile_wb_read_if #(
  parameter int AW = 5,
  parameter int DW = 64
);
  logic          RegWrite_reg_wb;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] data_to_reg;
  logic [AW-1:0] read_reg1;
  logic [AW-1:0] read_reg2;
  logic          stall;
  logic          flush;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
`ifdef REGFILE_DBG_EN
  logic [AW-1:0] dbg_reg;
  logic [DW-1:0] dbg_data;
  logic [31:0]   wr_count;

  modport master (
    output RegWrite_reg_wb, write_reg, data_to_reg, read_reg1, read_reg2,
           stall, flush, dbg_reg,
    input  read_data1, read_data2, dbg_data, wr_count
  );
  modport slave (
    input  RegWrite_reg_wb, write_reg, data_to_reg, read_reg1, read_reg2,
           stall, flush, dbg_reg,
    output read_data1, read_data2, dbg_data, wr_count
  );
`else
  modport master (
    output RegWrite_reg_wb, write_reg, data_to_reg, read_reg1, read_reg2,
           stall, flush,
    input  read_data1, read_data2
  );
  modport slave (
    input  RegWrite_reg_wb, write_reg, data_to_reg, read_reg1, read_reg2,
           stall, flush,
    output read_data1, read_data2
  );
`endif
endinterface

// File: rtl/regfile_wb_read.sv
// Integer register file with WB->decode bypass and registered ID/EX operands.
// Optional debug port and write counter under REGFILE_DBG_EN.
module regfile_rd_port #(
  parameter int NREGS = 32,
  parameter int DW    = 64,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          stall,
  input  logic [AW-1:0] idx,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [DW-1:0] wr_data,
  input  logic [DW-1:0] arr_data,
  output logic [DW-1:0] rd_data
);
  localparam logic [AW-1:0] XZR = AW'(NREGS - 1);

  logic          is_zr;
  logic          hit;
  logic [DW-1:0] nxt;

  assign is_zr = (idx == XZR);
  // XZR is checked first so a dropped XZR write never bypasses.
  assign hit   = wr_en && (wr_idx == idx);
  assign nxt   = is_zr ? '0 : (hit ? wr_data : arr_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rd_data <= '0;
    else if (flush)  rd_data <= '0;
    else if (!stall) rd_data <= nxt;
  end
endmodule

module regfile_wb_read #(
  parameter int NREGS = 32,
  parameter int DW    = 64,
  parameter int AW    = 5
) (
  input  logic               clk,
  input  logic               reset,
  regfile_wb_read_if.slave   bus
);
  localparam int            NUM_LANES = 2;
  localparam logic [AW-1:0] XZR       = AW'(NREGS - 1);

  logic [DW-1:0]                     mem [NREGS];
  logic                              wr_commit;
  logic [NUM_LANES-1:0][AW-1:0]      rd_idx;
  logic [NUM_LANES-1:0][DW-1:0]      rd_data;

  assign wr_commit = bus.RegWrite_reg_wb && (bus.write_reg != XZR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_commit) begin
      mem[bus.write_reg] <= bus.data_to_reg;
    end
  end

  assign rd_idx[0] = bus.read_reg1;
  assign rd_idx[1] = bus.read_reg2;

  // Read ports see pre-edge array contents; same-edge writes come via bypass.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_rd
    regfile_rd_port #(.NREGS(NREGS), .DW(DW), .AW(AW)) u_rd (
      .clk     (clk),
      .reset   (reset),
      .flush   (bus.flush),
      .stall   (bus.stall),
      .idx     (rd_idx[g]),
      .wr_en   (bus.RegWrite_reg_wb),
      .wr_idx  (bus.write_reg),
      .wr_data (bus.data_to_reg),
      .arr_data(mem[rd_idx[g]]),
      .rd_data (rd_data[g])
    );
  end

  assign bus.read_data1 = rd_data[0];
  assign bus.read_data2 = rd_data[1];

`ifdef REGFILE_DBG_EN
  logic [31:0] wr_cnt_q;

  assign bus.dbg_data = (bus.dbg_reg == XZR) ? '0 : mem[bus.dbg_reg];

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          wr_cnt_q <= '0;
    else if (wr_commit) wr_cnt_q <= wr_cnt_q + 32'd1;
  end

  assign bus.wr_count = wr_cnt_q;
`endif
endmodule

// File: tb/tb_regfile_wb_read.sv
// Directed + random bench for regfile_wb_read against an array-based model.
module tb_regfile_wb_read;
  localparam int NREGS = 32;
  localparam int DW    = 64;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic reset;
  int   tot = 0;
  int   bad = 0;

  logic [DW-1:0] model [NREGS];
  logic [DW-1:0] exp1, exp2;
  int unsigned   mcount;

  regfile_wb_read_if #(.AW(AW), .DW(DW)) bus ();

  regfile_wb_read #(.NREGS(NREGS), .DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input int wa, input logic [DW-1:0] wd,
                       input int r1, input int r2, input logic st, input logic fl);
    bus.RegWrite_reg_wb = we;
    bus.write_reg       = AW'(wa);
    bus.data_to_reg     = wd;
    bus.read_reg1       = AW'(r1);
    bus.read_reg2       = AW'(r2);
    bus.stall           = st;
    bus.flush           = fl;
  endtask

  function automatic logic [DW-1:0] ref_rd(input int idx, input logic [DW-1:0] cur);
    if (bus.flush) return '0;
    if (bus.stall) return cur;
    if (idx == NREGS - 1) return '0;
    if (bus.RegWrite_reg_wb && int'(bus.write_reg) == idx) return bus.data_to_reg;
    return model[idx];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    exp1   = '0;
    exp2   = '0;
    mcount = 0;
  endfunction

  // One clock: predict from pre-edge state, commit the write, check after the edge.
  task automatic cyc(input string tag);
    logic [DW-1:0] n1, n2;
    n1 = ref_rd(int'(bus.read_reg1), exp1);
    n2 = ref_rd(int'(bus.read_reg2), exp2);
    @(posedge clk);
    if (bus.RegWrite_reg_wb && int'(bus.write_reg) != NREGS - 1) begin
      model[bus.write_reg] = bus.data_to_reg;
      mcount++;
    end
    exp1 = n1;
    exp2 = n2;
    #1;
    chk({tag, "_rd1"}, bus.read_data1, exp1);
    chk({tag, "_rd2"}, bus.read_data2, exp2);
`ifdef REGFILE_DBG_EN
    chk({tag, "_cnt"}, DW'(bus.wr_count), DW'(mcount));
    chk({tag, "_dbg"}, bus.dbg_data,
        (int'(bus.dbg_reg) == NREGS - 1) ? '0 : model[bus.dbg_reg]);
`endif
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, '0, 0, 0, 0, 0);
`ifdef REGFILE_DBG_EN
    bus.dbg_reg = '0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd1", bus.read_data1, '0);
    chk("reset_rd2", bus.read_data2, '0);
    reset = 1'b0;

    // write then read
    drive(1, 5, 64'h0123_4567_89AB_CDEF, 0, 0, 0, 0); cyc("wr5");
    drive(0, 0, '0, 5, 0, 0, 0);                       cyc("rd5");
    chk("x5_val", bus.read_data1, 64'h0123_4567_89AB_CDEF);

    // bypass beats stale array contents; both ports agree
    drive(1, 7, 64'h11, 0, 0, 0, 0);                   cyc("wr7");
    drive(1, 7, 64'hDEAD_BEEF, 7, 7, 0, 0);            cyc("byp7");
    chk("byp_rd2", bus.read_data2, 64'hDEAD_BEEF);
    chk("byp_same", bus.read_data1, 64'hDEAD_BEEF);

    // XZR never bypasses and never stores
    drive(1, 31, '1, 31, 0, 0, 0);                     cyc("xzr_a");
    chk("xzr_same", bus.read_data1, '0);
    drive(0, 0, '0, 31, 31, 0, 0);                     cyc("xzr_b");
    chk("xzr_next", bus.read_data1, '0);

    // stall holds across a rewrite, flush wins over stall
    drive(1, 1, 64'hAA, 0, 0, 0, 0);                   cyc("wr1");
    drive(0, 0, '0, 1, 0, 0, 0);                       cyc("rd1");
    drive(1, 1, 64'hBB, 1, 0, 1, 0);                   cyc("stall");
    chk("stall_hold", bus.read_data1, 64'hAA);
    drive(0, 0, '0, 1, 0, 0, 0);                       cyc("unstall");
    chk("unstall_new", bus.read_data1, 64'hBB);
    drive(0, 0, '0, 1, 1, 1, 1);                       cyc("flush");
    chk("flush_zero", bus.read_data1, '0);

    // random traffic; a small index pool raises the bypass hit rate
    for (int n = 0; n < 400; n++) begin
      int pool;
      pool = ($urandom_range(0, 3) == 0) ? 31 : 7;
      drive(($urandom_range(0, 2) != 0), $urandom_range(0, pool),
            {$urandom, $urandom}, $urandom_range(0, pool), $urandom_range(0, pool),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0));
`ifdef REGFILE_DBG_EN
      bus.dbg_reg = AW'($urandom_range(0, 31));
`endif
      cyc("rnd");
    end

    // async reset mid-cycle with a nonzero operand registered
    drive(1, 3, 64'h3333, 0, 0, 0, 0);                 cyc("wr3");
    drive(0, 0, '0, 3, 3, 0, 0);                       cyc("rd3");
    #2 reset = 1'b1;
    #1;
    chk("async_rd1", bus.read_data1, '0);
    model_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    for (int i = 0; i < NREGS - 1; i++) begin
      drive(0, 0, '0, i, NREGS - 2 - i, 0, 0);
      cyc("post_rst");
    end
    chk("post_rst_x3", bus.read_data1, '0);

`ifdef REGFILE_DBG_EN
    drive(1, 31, 64'h99, 0, 0, 0, 0);
    bus.dbg_reg = AW'(2);                              cyc("dbg_x31");
    drive(1, 2, 64'h42, 0, 0, 0, 0);                   cyc("dbg_x2");
    chk("dbg_x2_val", bus.dbg_data, 64'h42);
    drive(1, 4, 64'h44, 0, 0, 0, 0);                   cyc("dbg_x4");
    chk("dbg_cnt2", DW'(bus.wr_count), DW'(2));
`endif

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
